// File: rtl/wb_commit_unit.sv
// Writeback commit stage: merges in-order pipeline results with a 2-deep queue of late load
// returns into one register-file write port, with read bypass and a per-register busy scoreboard.
module wb_commit_unit #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wb_regWrite,
    input  logic                  wb_memRead,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_memory_data,
    input  logic [DATA_WIDTH-1:0] wb_ALU_result,
    input  logic                  lr_valid,
    input  logic [4:0]            lr_rd,
    input  logic [DATA_WIDTH-1:0] lr_data,
    output logic                  lr_ready,
    input  logic                  sb_set,
    input  logic [4:0]            sb_rd,
    input  logic [4:0]            rs_addr,
    input  logic [4:0]            rt_addr,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] rt_data,
    output logic                  rs_busy,
    output logic                  rt_busy,
    output logic                  wb_write,
    output logic [4:0]            wb_write_reg,
    output logic [DATA_WIDTH-1:0] wb_write_data,
    output logic                  stall_req,
    output logic [1:0]            fifo_count
);

    if (CORE < 0 || ADDRESS_BITS < 1) begin : g_param_check
        $error("wb_commit_unit: CORE must be >= 0 and ADDRESS_BITS >= 1");
    end

    logic [DATA_WIDTH-1:0] regs [32];
    logic [31:0]           busy;
    logic [4:0]            q_rd   [2];
    logic [DATA_WIDTH-1:0] q_data [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;

    logic        pipe_commit;
    logic        deq;
    logic        enq;
    logic        late_commit;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    // Pipeline writes win the port; the queue head drains only in bubbles.
    assign pipe_commit = !reset && wb_regWrite && (wb_rd != 5'd0);
    assign deq         = !reset && !pipe_commit && (count != 2'd0);
    assign late_commit = deq && (q_rd[rd_ptr] != 5'd0);
    assign lr_ready    = !reset && (count != 2'd2);
    assign stall_req   = !reset && (count == 2'd2);
    assign enq         = lr_valid && lr_ready;
    assign fifo_count  = count;

    always_comb begin
        wb_write      = 1'b0;
        wb_write_reg  = '0;
        wb_write_data = '0;
        if (pipe_commit) begin
            wb_write      = 1'b1;
            wb_write_reg  = wb_rd;
            wb_write_data = wb_memRead ? wb_memory_data : wb_ALU_result;
        end else if (late_commit) begin
            wb_write      = 1'b1;
            wb_write_reg  = q_rd[rd_ptr];
            wb_write_data = q_data[rd_ptr];
        end
    end

    // r0 is never written and resets to zero, so the array read covers it.
    assign rs_data = (wb_write && (rs_addr == wb_write_reg)) ? wb_write_data : regs[rs_addr];
    assign rt_data = (wb_write && (rt_addr == wb_write_reg)) ? wb_write_data : regs[rt_addr];
    assign rs_busy = (rs_addr != 5'd0) && busy[rs_addr];
    assign rt_busy = (rt_addr != 5'd0) && busy[rt_addr];

    assign set_mask = (sb_set && (sb_rd != 5'd0)) ? (32'd1 << sb_rd) : 32'd0;
    assign clr_mask = late_commit ? (32'd1 << q_rd[rd_ptr]) : 32'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[wb_write_reg] <= wb_write_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy   <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
            if (enq) begin
                wr_ptr <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            q_rd[wr_ptr]   <= lr_rd;
            q_data[wr_ptr] <= lr_data;
        end
    end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: a queue/array reference model checked every cycle, plus
// directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_wb_commit_unit;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          wb_regWrite, wb_memRead;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_memory_data, wb_ALU_result;
    logic          lr_valid;
    logic [4:0]    lr_rd;
    logic [DW-1:0] lr_data;
    logic          lr_ready;
    logic          sb_set;
    logic [4:0]    sb_rd;
    logic [4:0]    rs_addr, rt_addr;
    logic [DW-1:0] rs_data, rt_data;
    logic          rs_busy, rt_busy;
    logic          wb_write;
    logic [4:0]    wb_write_reg;
    logic [DW-1:0] wb_write_data;
    logic          stall_req;
    logic [1:0]    fifo_count;

    wb_commit_unit #(.CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(20)) dut (
        .clock(clock), .reset(reset),
        .wb_regWrite(wb_regWrite), .wb_memRead(wb_memRead), .wb_rd(wb_rd),
        .wb_memory_data(wb_memory_data), .wb_ALU_result(wb_ALU_result),
        .lr_valid(lr_valid), .lr_rd(lr_rd), .lr_data(lr_data), .lr_ready(lr_ready),
        .sb_set(sb_set), .sb_rd(sb_rd),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .rs_busy(rs_busy), .rt_busy(rt_busy),
        .wb_write(wb_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .stall_req(stall_req), .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural register values, busy set, and queue of {rd,data}.
    logic [DW-1:0] m_regs [32];
    bit            m_busy [32];
    logic [36:0]   m_q [$];

    function automatic void model_commit(output logic w, output logic [4:0] r, output logic [DW-1:0] d);
        w = 1'b0; r = '0; d = '0;
        if (reset) return;
        if (wb_regWrite && wb_rd != 5'd0) begin
            w = 1'b1; r = wb_rd; d = wb_memRead ? wb_memory_data : wb_ALU_result;
        end else if (m_q.size() > 0 && m_q[0][36:32] != 5'd0) begin
            w = 1'b1; r = m_q[0][36:32]; d = m_q[0][31:0];
        end
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [4:0] a, input logic w,
                                                 input logic [4:0] r, input logic [DW-1:0] d);
        if (w && a == r) return d;
        if (a == 5'd0) return '0;
        return m_regs[a];
    endfunction

    always @(posedge clock or posedge reset) begin
        int          sz;
        logic        w;
        logic [4:0]  r;
        logic [DW-1:0] d;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_q.delete();
        end else begin
            sz = m_q.size();
            model_commit(w, r, d);
            if (w) m_regs[r] = d;
            if (!(wb_regWrite && wb_rd != 5'd0) && sz > 0) begin
                if (m_q[0][36:32] != 5'd0) m_busy[m_q[0][36:32]] = 1'b0;
                void'(m_q.pop_front());
            end
            if (sb_set && sb_rd != 5'd0) m_busy[sb_rd] = 1'b1;
            if (lr_valid && sz < 2) m_q.push_back({lr_rd, lr_data});
        end
    end

    always @(negedge clock) begin
        logic        w;
        logic [4:0]  r;
        logic [DW-1:0] d;
        model_commit(w, r, d);
        chk("m_wb_write", wb_write, w);
        chk("m_wb_write_reg", wb_write_reg, r);
        chk("m_wb_write_data", wb_write_data, d);
        chk("m_rs_data", rs_data, model_read(rs_addr, w, r, d));
        chk("m_rt_data", rt_data, model_read(rt_addr, w, r, d));
        chk("m_rs_busy", rs_busy, (rs_addr != 5'd0) && m_busy[rs_addr]);
        chk("m_rt_busy", rt_busy, (rt_addr != 5'd0) && m_busy[rt_addr]);
        chk("m_fifo_count", fifo_count, reset ? 0 : m_q.size());
        chk("m_lr_ready", lr_ready, !reset && m_q.size() < 2);
        chk("m_stall_req", stall_req, !reset && m_q.size() == 2);
    end

    task automatic idle();
        wb_regWrite = 0; wb_memRead = 0; wb_rd = 0; wb_memory_data = 0; wb_ALU_result = 0;
        lr_valid = 0; lr_rd = 0; lr_data = 0; sb_set = 0; sb_rd = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle();
        rs_addr = 0; rt_addr = 0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_lr_ready", lr_ready, 0);
        chk("rst_wb_write", wb_write, 0);
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_lr_ready", lr_ready, 1);
        step();

        // Pipeline commit with bypass
        wb_regWrite = 1; wb_rd = 5; wb_ALU_result = 32'h1234; wb_memory_data = 32'h5555; rs_addr = 5;
        @(negedge clock);
        chk("p_write", wb_write, 1);
        chk("p_reg", wb_write_reg, 5);
        chk("p_data", wb_write_data, 32'h1234);
        chk("p_bypass", rs_data, 32'h1234);
        step(); idle();
        @(negedge clock);
        chk("p_stored_r5", rs_data, 32'h1234);
        step();

        // Writes to r0 are dropped
        wb_regWrite = 1; wb_rd = 0; wb_memRead = 1;
        wb_memory_data = 32'hFFFF_FFFF; wb_ALU_result = 32'hFFFF_FFFF; rs_addr = 0;
        @(negedge clock);
        chk("r0_write_mem", wb_write, 0);
        chk("r0_read", rs_data, 0);
        step(); wb_memRead = 0;
        @(negedge clock);
        chk("r0_write_alu", wb_write, 0);
        step();

        // Memory data select
        wb_rd = 6; wb_memRead = 1; wb_memory_data = 32'hDEAD_BEEF; wb_ALU_result = 32'h0BAD;
        @(negedge clock);
        chk("memsel_data", wb_write_data, 32'hDEAD_BEEF);
        step(); idle(); rt_addr = 6;
        @(negedge clock);
        chk("memsel_r6", rt_data, 32'hDEAD_BEEF);
        step();

        // Late load held off by continuous pipeline writes, drains on bubble
        sb_set = 1; sb_rd = 7; wb_regWrite = 1; wb_rd = 1; wb_ALU_result = 32'h11;
        step();
        sb_set = 0; lr_valid = 1; lr_rd = 7; lr_data = 32'hAA; wb_ALU_result = 32'h12; rs_addr = 7;
        @(negedge clock);
        chk("ll_busy7_set", rs_busy, 1);
        step();
        lr_valid = 0; wb_ALU_result = 32'h13;
        @(negedge clock);
        chk("ll_queued", fifo_count, 1);
        chk("ll_pipe_priority", wb_write_reg, 1);
        step();
        wb_regWrite = 0;
        @(negedge clock);
        chk("ll_commit_reg", wb_write_reg, 7);
        chk("ll_commit_data", wb_write_data, 32'hAA);
        step();
        @(negedge clock);
        chk("ll_busy7_clear", rs_busy, 0);
        chk("ll_r7", rs_data, 32'hAA);
        step();

        // Queue fills, third beat refused, in-order drain
        wb_regWrite = 1; wb_rd = 2; wb_ALU_result = 32'h20; lr_valid = 1; lr_rd = 10; lr_data = 32'hA0;
        step();
        lr_rd = 11; lr_data = 32'hB0; wb_ALU_result = 32'h21;
        step();
        lr_rd = 12; lr_data = 32'hC0;
        @(negedge clock);
        chk("full_lr_ready", lr_ready, 0);
        chk("full_stall", stall_req, 1);
        chk("full_count", fifo_count, 2);
        step();
        lr_valid = 0; wb_regWrite = 0;
        @(negedge clock);
        chk("drain1_reg", wb_write_reg, 10);
        chk("drain1_data", wb_write_data, 32'hA0);
        step();
        @(negedge clock);
        chk("drain2_reg", wb_write_reg, 11);
        chk("drain2_data", wb_write_data, 32'hB0);
        step();
        rs_addr = 12;
        @(negedge clock);
        chk("drain_empty", fifo_count, 0);
        chk("refused_r12", rs_data, 0);
        step();

        // rd=0 queue entry pops silently; same-cycle set and clear on r9 keeps busy
        sb_set = 1; sb_rd = 9; wb_regWrite = 1; wb_rd = 3; wb_ALU_result = 32'h30;
        lr_valid = 1; lr_rd = 0; lr_data = 32'h55;
        step();
        sb_set = 0; lr_rd = 9; lr_data = 32'h99;
        step();
        lr_valid = 0; wb_regWrite = 0;
        @(negedge clock);
        chk("rd0_pop_write", wb_write, 0);
        step();
        sb_set = 1; sb_rd = 9; rs_addr = 9;
        @(negedge clock);
        chk("r9_commit_reg", wb_write_reg, 9);
        chk("r9_count", fifo_count, 1);
        step();
        sb_set = 0;
        @(negedge clock);
        chk("r9_busy_set_wins", rs_busy, 1);
        chk("r9_data", rs_data, 32'h99);
        step();

        // Mid-operation reset with a full queue
        sb_set = 1; sb_rd = 4; wb_regWrite = 1; wb_rd = 8; wb_ALU_result = 32'h80;
        lr_valid = 1; lr_rd = 4; lr_data = 32'h40;
        step();
        sb_set = 0; lr_rd = 5; lr_data = 32'h50;
        step();
        lr_valid = 0; rs_addr = 4;
        @(negedge clock);
        chk("pre_rst_count", fifo_count, 2);
        chk("pre_rst_busy4", rs_busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_count", fifo_count, 0);
        chk("async_rst_lr_ready", lr_ready, 0);
        chk("async_rst_wb_write", wb_write, 0);
        chk("async_rst_busy4", rs_busy, 0);
        step();
        reset = 1'b0; idle();
        #1;
        chk("rst_exit_lr_ready", lr_ready, 1);
        for (int a = 1; a < 32; a++) begin
            rs_addr = a[4:0]; rt_addr = a[4:0];
            @(negedge clock);
            chk("rst_clear_data", rs_data, 0);
            chk("rst_clear_busy", rt_busy, 0);
            chk("rst_no_late", wb_write, 0);
            step();
        end

        // Mixed traffic, pipeline honours the stall
        for (int n = 0; n < 80; n++) begin
            wb_regWrite = (m_q.size() == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            wb_memRead = 1'($urandom_range(0, 1));
            wb_rd = 5'($urandom_range(0, 31));
            wb_memory_data = $urandom; wb_ALU_result = $urandom;
            lr_valid = 1'($urandom_range(0, 1));
            lr_rd = 5'($urandom_range(0, 31)); lr_data = $urandom;
            sb_set = 1'($urandom_range(0, 1)); sb_rd = 5'($urandom_range(0, 31));
            rs_addr = 5'($urandom_range(0, 31)); rt_addr = wb_rd;
            step();
        end
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_commit_unit.md
WB_COMMIT_UNIT -- requirements
Module: wb_commit_unit

Interface
REQ-001 Parameter CORE, default 0, core index for multi-core instantiation; no functional effect.
REQ-002 Parameter DATA_WIDTH, default 32, register and data width.
REQ-003 Parameter ADDRESS_BITS, default 20, memory address width; no functional effect in this block.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 wb_regWrite  input  1  pipeline writeback request.
REQ-007 wb_memRead  input  1  1 selects wb_memory_data, 0 selects wb_ALU_result.
REQ-008 wb_rd  input  5  pipeline destination register.
REQ-009 wb_memory_data, wb_ALU_result  input  DATA_WIDTH  pipeline result candidates.
REQ-010 lr_valid  input  1  late-load return offered.
REQ-011 lr_rd  input  5  late-load destination register.
REQ-012 lr_data  input  DATA_WIDTH  late-load data.
REQ-013 lr_ready  output  1  late-load return accepted when lr_valid and lr_ready are both 1.
REQ-014 sb_set  input  1  marks register sb_rd busy for an outstanding late load.
REQ-015 sb_rd  input  5  register to mark busy.
REQ-016 rs_addr, rt_addr  input  5  read addresses.
REQ-017 rs_data, rt_data  output  DATA_WIDTH  read data.
REQ-018 rs_busy, rt_busy  output  1  scoreboard bit of rs_addr / rt_addr.
REQ-019 wb_write  output  1  a register commit occurs this cycle.
REQ-020 wb_write_reg  output  5  committed register.
REQ-021 wb_write_data  output  DATA_WIDTH  committed data.
REQ-022 stall_req  output  1  requests a pipeline bubble so queued late loads can drain.
REQ-023 fifo_count  output  2  late-load queue occupancy, 0..2.

Function
REQ-024 Register file: 32 x DATA_WIDTH entries; r0 always reads 0 and is never written.
REQ-025 Pipeline commit: active when wb_regWrite=1 and wb_rd!=0; data = wb_memRead ? wb_memory_data : wb_ALU_result; written at the next rising edge.
REQ-026 Late-load queue: 2-entry FIFO of {rd, data}; lr_ready = (fifo_count<2), with no credit for a same-cycle dequeue.
REQ-027 Acceptance enqueues at the rising edge; an entry is committed no earlier than the cycle after acceptance.
REQ-028 Queue head commits only in cycles with no pipeline commit; pipeline commit always has priority.
REQ-029 Dequeue of a head entry with rd=0: entry is popped, wb_write=0, no register changes.
REQ-030 Simultaneous enqueue and dequeue: fifo_count unchanged and order preserved.
REQ-031 wb_write, wb_write_reg, wb_write_data combinationally reflect the commit selected this cycle; when no commit occurs, all three are 0.
REQ-032 Read bypass: if wb_write=1 and the read address equals wb_write_reg, the read returns wb_write_data; otherwise it returns the stored value (0 for r0).
REQ-033 Scoreboard: 32 busy bits. sb_set with sb_rd!=0 sets busy[sb_rd]; a late-load commit to rd clears busy[rd]. If set and clear target the same register in one cycle, set wins.
REQ-034 A pipeline commit does not change any busy bit.
REQ-035 rs_busy/rt_busy are combinational from the registered busy bits; address 0 always reports 0.
REQ-036 stall_req = 1 when fifo_count=2; the pipeline then holds wb_regWrite=0 for at least one cycle.

Reset
REQ-037 While reset=1: all registers = 0, queue empty (fifo_count=0), busy bits = 0, lr_ready=0, stall_req=0, wb_write=0, wb_write_reg=0, wb_write_data=0.
REQ-038 Reset asserted mid-operation discards queued late loads immediately; lr_ready returns to 1 in the first cycle after reset deasserts.

Verification
REQ-039 wb_regWrite=1, wb_rd=5, wb_memRead=0, wb_ALU_result=0x1234 -> same cycle: wb_write=1, wb_write_reg=5, wb_write_data=0x1234, and rs_addr=5 reads 0x1234; after the edge, r5 = 0x1234.
REQ-040 Write rd=0 with data 0xFFFF_FFFF from both sources -> wb_write=0 and r0 reads 0.
REQ-041 sb_set rd=7; lr {7, 0xAA} accepted while the pipeline writes every cycle -> busy[7]=1 and no late commit; first bubble -> wb_write_reg=7, wb_write_data=0xAA; after the edge, rs_busy=0 for rs_addr=7.
REQ-042 Three back-to-back lr_valid beats with continuous pipeline writes -> first two accepted, lr_ready=0 and stall_req=1 on the third, fifo_count=2; entries drain in order.
REQ-043 Same-cycle sb_set rd=9 and late-load commit to r9 -> busy[9]=1 after the edge.
REQ-044 Reset asserted with fifo_count=2 -> fifo_count=0, all busy bits cleared, r1..r31 read 0, no late commit after reset deasserts.
